// File: rtl/regfile_pkg.sv
// Shared types and constants for the forwarding register file.
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_CLEAR = 1'b0,
    RF_RUN   = 1'b1
  } rf_state_t;

  localparam int unsigned RF_ZERO_ADDR = 0;
  localparam int unsigned RF_MAX_READ  = 4;

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: zero register, clear masking and write bypass.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  rf_state_t              state,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic                   write_en,
  input  logic [ADDR_WIDTH-1:0]  write_addr,
  input  logic [DATA_WIDTH-1:0]  write_data,
  input  logic [DATA_WIDTH-1:0]  stored,
  output logic [DATA_WIDTH-1:0]  data
);

  always_comb begin
    data = '0;
    if (addr != ADDR_WIDTH'(RF_ZERO_ADDR) && state == RF_RUN) begin
      if (write_en && write_addr == addr) begin
        data = write_data;
      end else begin
        data = stored;
      end
    end
  end

endmodule

// File: rtl/regfile_fwd.sv
// Parametrised register file with write bypass, hard-wired zero register and a
// post-reset clear sweep that gates writes until every register is zeroed.
module regfile_fwd
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned NUM_REGS   = 32,
  parameter int unsigned ADDR_WIDTH = $clog2(NUM_REGS),
  parameter int unsigned NUM_READ   = 2
) (
  input  logic                           Clk,
  input  logic                           Rst,
  input  logic                           write_En,
  input  logic [ADDR_WIDTH-1:0]          writeAddr,
  input  logic [DATA_WIDTH-1:0]          data_in,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] addr_rd,
  output logic [NUM_READ*DATA_WIDTH-1:0] data_rd,
  output logic                           ready,
  output logic                           write_Drop
);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  rf_state_t             state;
  logic [ADDR_WIDTH-1:0] clr_idx;
  logic                  drop_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state   <= RF_CLEAR;
      clr_idx <= ADDR_WIDTH'(1);
      drop_q  <= 1'b0;
    end else begin
      drop_q <= (state == RF_CLEAR) && write_En;
      if (state == RF_CLEAR) begin
        clr_idx <= clr_idx + 1'b1;
        if (clr_idx == ADDR_WIDTH'(NUM_REGS - 1)) begin
          state <= RF_RUN;
        end
      end
    end
  end

  // Register 0 is never written; every read port masks it to zero instead.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      if (state == RF_CLEAR) begin
        regs[clr_idx] <= '0;
      end else if (write_En && writeAddr != ADDR_WIDTH'(RF_ZERO_ADDR)) begin
        regs[writeAddr] <= data_in;
      end
    end
  end

  assign ready      = (state == RF_RUN);
  assign write_Drop = drop_q;

  for (genvar p = 0; p < NUM_READ; p++) begin : g_port
    logic [ADDR_WIDTH-1:0] addr;
    assign addr = addr_rd[p*ADDR_WIDTH +: ADDR_WIDTH];

    regfile_read_port #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port (
      .state      (state),
      .addr       (addr),
      .write_en   (write_En),
      .write_addr (writeAddr),
      .write_data (data_in),
      .stored     (regs[addr]),
      .data       (data_rd[p*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule

// File: doc/regfile_fwd.md
# regfile_fwd

Parametrised register file, successor to the current 32×64 single-write/dual-read file, for the datapath's decode/writeback stage. Depth, width and read-port count are parameters. Register 0 is hard-wired to zero on every read port. Reads see same-cycle writes through a bypass path. After reset, a sequential clear sweep zeroes every register, with `ready` reporting when the sweep is finished.

## Interface
- `DATA_WIDTH`, 64, bits per register.
- `NUM_REGS`, 32, register count; power of two, ≥ 2.
- `ADDR_WIDTH`, `$clog2(NUM_REGS)`, address width.
- `NUM_READ`, 2, read-port count; 1 to 4.
- `Clk` input 1: the single clock; all state updates on its rising edge.
- `Rst` input 1: synchronous reset, active-high.
- `write_En` input 1: write strobe.
- `writeAddr` input `ADDR_WIDTH`: write address.
- `data_in` input `DATA_WIDTH`: write data.
- `addr_rd` input `NUM_READ*ADDR_WIDTH`: packed read addresses; port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- `data_rd` output `NUM_READ*DATA_WIDTH`: packed read data, same packing as `addr_rd`.
- `ready` output 1: high when the clear sweep is done and writes are accepted.
- `write_Drop` output 1: registered pulse; high for one cycle after a write strobe is rejected.

## Operation
- The state machine has two states.
  - CLEAR: reset value.
  - RUN.
- While `Rst` is high:
  - state = CLEAR, clear index `clr_idx` = 1.
  - `ready` = 0, `write_Drop` = 0.
  - Storage is not written.
- CLEAR, with `Rst` low:
  - Each cycle writes 0 to register `clr_idx`, then increments `clr_idx`.
  - On the edge that clears register NUM_REGS-1, the state moves to RUN.
- RUN:
  - A write with `write_En`=1 and `writeAddr`≠0 updates the register at the rising edge.
  - A write to address 0 is silently discarded. It is not a drop.
- Write in CLEAR: a `write_En` strobe is ignored and `write_Drop` pulses the next cycle. The sweep is never modified by a write.
- Read, combinational, per port p:
  - Address 0: output 0.
  - Else if state = CLEAR: output 0.
  - Else if `write_En`=1 and `writeAddr` equals the port address: output `data_in` (bypass).
  - Else: the stored register value.
- Ports are independent. Any number of ports may read the same address in the same cycle.
- `Rst` asserted during CLEAR or RUN restarts the sweep from `clr_idx`=1. Data is not guaranteed until `ready` is high again.

## Timing
- Read latency is 0 cycles (combinational), including the bypass path.
- Write visibility:
  - Visible on the read ports in the same cycle through the bypass.
  - Visible from storage from the next cycle onward.
- Clear duration: `ready` rises exactly NUM_REGS-1 cycles after the first rising edge that samples `Rst`=0. With defaults this is 31 cycles.
- `write_Drop` is registered: it is high during cycle n+1 for a rejected strobe in cycle n.
- A write in the same cycle that `ready` first reads 1 (state is RUN) is accepted.
- No write-after-write hazard exists because there is a single write port. Back-to-back writes to the same address are legal; the last one wins.

## Structure
- Shared package `regfile_pkg`:
  - State enum `rf_state_t` {RF_CLEAR, RF_RUN}.
  - Constant `RF_ZERO_ADDR` = 0.
  - Maximum `NUM_READ` constant = 4.
- One sub-module, `regfile_read_port`:
  - Instantiated NUM_READ times with a generate loop.
  - Contains the zero-address, clear-state and bypass mux for one port.
- Storage array, clear FSM and `write_Drop` register live in the top module.

## Test plan
- Reset, defaults: hold `Rst`=1 for 3 cycles, then release.
  - `ready`=0 for exactly 31 cycles, then 1.
  - All reads of addresses 0–31 return 0.
- Write/readback: write 0xDEAD_BEEF_0000_0001 to address 5.
  - Port 0 reads address 5 in the same cycle and gets the value (bypass).
  - Next cycle, port 1 reads 5 from storage and gets the same value.
- Zero register: write 0xFFFF_FFFF_FFFF_FFFF to address 0; both ports read address 0 → 0. `write_Drop` stays 0.
- Write during clear: assert `write_En`, address 7, data 0x1234 at cycle 10 of the sweep.
  - `write_Drop`=1 at cycle 11.
  - After `ready`, address 7 reads 0.
- Reset mid-operation:
  - Fill addresses 1–31 with the index value.
  - Assert `Rst` for 1 cycle; 31 cycles after release, every address reads 0.
  - Also assert `Rst` at cycle 15 of a sweep: the sweep restarts and `ready` comes 31 cycles after the second release.
- Parameter sweep: with NUM_REGS=8, DATA_WIDTH=16, NUM_READ=4, all four ports read address 3 while 0xA5A5 is written to 3.
  - All four ports return 0xA5A5.
  - The clear takes 7 cycles.
